// File: rtl/grace_slave_regs.sv
// Grace-bus register-file responder with WS wait states and an edge-captured interrupt block.
// Optional interrupt logic (ISTAT/IEN/Irq_Src) is built when GRACE_SLV_IRQ_EN is defined.
module grace_slave_regs #(
  parameter int              AW     = 4,
  parameter int              DW     = 32,
  parameter int              WN     = 1,
  parameter int              NREG   = 16,
  parameter int              WS     = 0,
  parameter int              IL     = 1,
  parameter int              IW     = 8,
  parameter logic [DW-1:0]   ID     = 32'hCA050001,
  parameter logic [DW-1:0]   ERR_RD = 32'hDEADC0DE
) (
  input  logic          Grace_Ck,
  input  logic          Grace_Rs,
  input  logic          Grace_CE,
  input  logic          Grace_CS,
  input  logic [WN-1:0] Grace_WR,
  input  logic [AW-1:0] Grace_Ad,
  input  logic [DW-1:0] Grace_WD,
  output logic          Grace_Ac,
  output logic          Grace_Re,
  output logic [DW-1:0] Grace_RD,
  output logic          Grace_IR,
  input  logic [IW-1:0] Irq_Src
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [AW:0]   NREG_L  = (AW+1)'(NREG);
  localparam logic [AW-1:0] A_ISTAT = AW'(2);
  localparam logic [AW-1:0] A_IEN   = AW'(3);

  state_t        st, st_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] ad_q;
  logic          wr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] regs [2**AW];
  logic [DW-1:0] rd_val;
  logic          err, enter_resp, gp_we;

  // Every access passes through WAIT (cnt counts down to 0), so Ac rises
  // WS+1 enabled edges after CS is first sampled in IDLE.
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    case (st)
      IDLE: if (Grace_CS) begin
              st_nx  = WAIT;
              cnt_nx = 4'(WS);
            end
      WAIT: if (!Grace_CS)     st_nx  = IDLE;
            else if (cnt == '0) st_nx = RESP;
            else               cnt_nx = cnt - 4'd1;
      RESP: if (!Grace_CS)     st_nx  = IDLE;
      default:                 st_nx  = IDLE;
    endcase
  end

  assign enter_resp = (st == WAIT) && Grace_CS && (cnt == '0);
  assign err        = ({1'b0, ad_q} >= NREG_L);
  assign gp_we      = enter_resp && wr_q && !err && (ad_q != '0) &&
                      (ad_q != A_ISTAT) && (ad_q != A_IEN);

`ifdef GRACE_SLV_IRQ_EN
  logic [IW-1:0] src_q, istat, ien, rise, w1c;
  logic          ir_q;

  assign rise = Irq_Src & ~src_q;
  assign w1c  = (enter_resp && wr_q && ad_q == A_ISTAT) ? wd_q[IW-1:0] : '0;

  // Clear is applied before set so a same-edge source edge keeps the bit.
  always_ff @(posedge Grace_Ck) begin
    if (!Grace_Rs) begin
      src_q <= '0;
      istat <= '0;
      ien   <= '0;
      ir_q  <= 1'b0;
    end else if (Grace_CE) begin
      src_q <= Irq_Src;
      istat <= (istat & ~w1c) | rise;
      if (enter_resp && wr_q && ad_q == A_IEN) ien <= wd_q[IW-1:0];
      ir_q  <= |(istat & ien);
    end
  end

  assign Grace_IR = (IL != 0) ? ir_q : ~ir_q;
`else
  logic unused_irq;
  assign unused_irq = ^Irq_Src;
  assign Grace_IR   = (IL != 0) ? 1'b0 : 1'b1;
`endif

  // Addresses 0, 2 and 3 are never stored in regs, so their slots read 0.
  always_comb begin
    rd_val = regs[ad_q];
    if (ad_q == '0) rd_val = ID;
`ifdef GRACE_SLV_IRQ_EN
    if (ad_q == A_ISTAT) rd_val = DW'(istat);
    if (ad_q == A_IEN)   rd_val = DW'(ien);
`endif
  end

  always_ff @(posedge Grace_Ck) begin
    if (!Grace_Rs) begin
      st       <= IDLE;
      cnt      <= '0;
      ad_q     <= '0;
      wr_q     <= 1'b0;
      wd_q     <= '0;
      Grace_Ac <= 1'b0;
      Grace_Re <= 1'b0;
      Grace_RD <= '0;
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (Grace_CE) begin
      st  <= st_nx;
      cnt <= cnt_nx;
      if (st == IDLE && Grace_CS) begin
        ad_q <= Grace_Ad;
        wr_q <= |Grace_WR;
        wd_q <= Grace_WD;
      end
      if (enter_resp) begin
        Grace_Ac <= 1'b1;
        Grace_Re <= err;
        Grace_RD <= err ? ERR_RD : rd_val;
      end else if (st == RESP && !Grace_CS) begin
        Grace_Ac <= 1'b0;
        Grace_Re <= 1'b0;
      end
      if (gp_we) regs[ad_q] <= wd_q;
    end
  end

endmodule
